ahb_lite_master_arbiter: RTL and testbench

//  Shares one AHB-Lite slave-side bus between NUM_MASTERS AHB-Lite masters (picorv32 core wrappers) in the

---
 rtl/ahb_pkg.sv | 31 +++
 rtl/rr_pick.sv | 43 ++++
 rtl/ahb_lite_master_arbiter.sv | 136 +++++++++++++
 tb/tb_ahb_lite_master_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : AHB-Lite transfer-type and transfer-size encodings shared by
//                the master arbiter and the picorv32 core wrappers.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // A transfer is being requested whenever HTRANS[1] is set (NONSEQ/SEQ).
    function automatic logic is_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage : ahb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches req starting at
//                ptr and wrapping modulo N; returns the first requester.
//                With no requester, gnt parks on ptr and any is low.
//  Ports       : req [N]  request vector
//                ptr [MW] highest-priority index for this search
//                gnt [MW] selected index
//                any      at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] ptr,
    output logic [MW-1:0] gnt,
    output logic          any
);

    // One extra bit so ptr+k never overflows before the modulo fold.
    logic [MW:0] w_idx;

    always_comb begin
        gnt   = ptr;
        any   = 1'b0;
        w_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, ptr} + (MW+1)'(k);
            if (w_idx >= (MW+1)'(N)) begin
                w_idx = w_idx - (MW+1)'(N);
            end
            if (!any && req[w_idx[MW-1:0]]) begin
                gnt = w_idx[MW-1:0];
                any = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/ahb_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_master_arbiter
//  Description : Shares one AHB-Lite slave port between NUM_MASTERS masters.
//                Round-robin address-phase arbitration, data-phase routing
//                and per-master HREADY stalling (no HBUSREQ/HGRANT).
//  Ports       : HCLK/HRESETn            clock, async active-low reset
//                H*_m [N]                per-master AHB-Lite master ports
//                HADDR..HMASTLOCK        shared address/control to slave
//                HWDATA                  shared write data (data-phase owner)
//                HRDATA/HREADY/HRESP     shared slave response
//                HMASTER                 current address-phase owner
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_lite_master_arbiter
    import ahb_pkg::*;
#(
    parameter  int NUM_MASTERS = 4,
    localparam int MW          = $clog2(NUM_MASTERS)
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    // master side
    input  logic [NUM_MASTERS-1:0][31:0] HADDR_m,
    input  logic [NUM_MASTERS-1:0]       HWRITE_m,
    input  logic [NUM_MASTERS-1:0][1:0]  HTRANS_m,
    input  logic [NUM_MASTERS-1:0][2:0]  HSIZE_m,
    input  logic [NUM_MASTERS-1:0][2:0]  HBURST_m,
    input  logic [NUM_MASTERS-1:0][3:0]  HPROT_m,
    input  logic [NUM_MASTERS-1:0]       HMASTLOCK_m,
    input  logic [NUM_MASTERS-1:0][31:0] HWDATA_m,
    output logic [NUM_MASTERS-1:0][31:0] HRDATA_m,
    output logic [NUM_MASTERS-1:0]       HREADY_m,
    output logic [NUM_MASTERS-1:0]       HRESP_m,
    // slave side
    output logic [31:0]                  HADDR,
    output logic                         HWRITE,
    output logic [1:0]                   HTRANS,
    output logic [2:0]                   HSIZE,
    output logic [2:0]                   HBURST,
    output logic [3:0]                   HPROT,
    output logic                         HMASTLOCK,
    output logic [31:0]                  HWDATA,
    input  logic [31:0]                  HRDATA,
    input  logic                         HREADY,
    input  logic                         HRESP,
    output logic [MW-1:0]                HMASTER
);

    localparam logic [MW-1:0] c_last = MW'(NUM_MASTERS - 1);

    logic [MW-1:0]          r_ptr;
    logic                   r_hold;
    logic [MW-1:0]          r_hgnt;
    logic [MW-1:0]          r_d_own;
    logic                   r_d_valid;

    logic [NUM_MASTERS-1:0] w_req;
    logic [MW-1:0]          w_pick;
    logic                   w_any;
    logic [MW-1:0]          w_g;
    logic                   w_req_g;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_req
            assign w_req[gi] = is_active(HTRANS_m[gi]);
        end
    endgenerate

    rr_pick #(
        .N  (NUM_MASTERS),
        .MW (MW)
    ) u_rr_pick (
        .req (w_req),
        .ptr (r_ptr),
        .gnt (w_pick),
        .any (w_any)
    );

    // While a NONSEQ is waited on by the slave the grant is frozen so the
    // address phase on the shared bus stays stable.
    assign w_g     = r_hold ? r_hgnt : w_pick;
    assign w_req_g = r_hold ? w_req[r_hgnt] : w_any;

    // Shared address/control follows the grant combinationally, giving a
    // zero-cycle grant to an uncontended master.
    assign HADDR     = HADDR_m[w_g];
    assign HWRITE    = HWRITE_m[w_g];
    assign HTRANS    = HTRANS_m[w_g];
    assign HSIZE     = HSIZE_m[w_g];
    assign HBURST    = HBURST_m[w_g];
    assign HPROT     = HPROT_m[w_g];
    assign HMASTLOCK = HMASTLOCK_m[w_g];
    assign HMASTER   = w_g;
    assign HWDATA    = HWDATA_m[r_d_own];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ptr     <= '0;
            r_hold    <= 1'b0;
            r_hgnt    <= '0;
            r_d_own   <= '0;
            r_d_valid <= 1'b0;
        end else if (HREADY) begin
            r_hold <= 1'b0;
            if (w_req_g) begin
                r_d_own   <= w_g;
                r_d_valid <= 1'b1;
                r_ptr     <= (w_g == c_last) ? '0 : w_g + 1'b1;
            end else begin
                r_d_valid <= 1'b0;
            end
        end else if (w_req_g) begin
            r_hold <= 1'b1;
            r_hgnt <= w_g;
        end
    end

    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            logic w_is_g;
            logic w_is_d;
            assign w_is_g = (w_g == MW'(gi));
            assign w_is_d = r_d_valid && (r_d_own == MW'(gi));

            assign HRDATA_m[gi] = HRDATA;
            assign HRESP_m[gi]  = w_is_d ? HRESP : 1'b0;
            // A requester that is neither granted nor in its data phase is
            // stalled; an idle master is never held off.
            assign HREADY_m[gi] = (w_is_g || w_is_d) ? HREADY : !w_req[gi];
        end
    endgenerate

endmodule : ahb_lite_master_arbiter
`default_nettype wire

// File: tb/tb_ahb_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_lite_master_arbiter
//  Description : Self-checking bench for ahb_lite_master_arbiter (4 masters).
//                Table of per-cycle vectors plus directed multi-cycle
//                sequences for pipelining, async reset and round-robin.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_lite_master_arbiter;

    localparam int N = 4;

    logic                HCLK;
    logic                HRESETn;
    logic [N-1:0][31:0]  HADDR_m;
    logic [N-1:0]        HWRITE_m;
    logic [N-1:0][1:0]   HTRANS_m;
    logic [N-1:0][2:0]   HSIZE_m;
    logic [N-1:0][2:0]   HBURST_m;
    logic [N-1:0][3:0]   HPROT_m;
    logic [N-1:0]        HMASTLOCK_m;
    logic [N-1:0][31:0]  HWDATA_m;
    logic [N-1:0][31:0]  HRDATA_m;
    logic [N-1:0]        HREADY_m;
    logic [N-1:0]        HRESP_m;
    logic [31:0]         HADDR;
    logic                HWRITE;
    logic [1:0]          HTRANS;
    logic [2:0]          HSIZE;
    logic [2:0]          HBURST;
    logic [3:0]          HPROT;
    logic                HMASTLOCK;
    logic [31:0]         HWDATA;
    logic [31:0]         HRDATA;
    logic                HREADY;
    logic                HRESP;
    logic [1:0]          HMASTER;

    ahb_lite_master_arbiter #(.NUM_MASTERS(N)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR_m     (HADDR_m),
        .HWRITE_m    (HWRITE_m),
        .HTRANS_m    (HTRANS_m),
        .HSIZE_m     (HSIZE_m),
        .HBURST_m    (HBURST_m),
        .HPROT_m     (HPROT_m),
        .HMASTLOCK_m (HMASTLOCK_m),
        .HWDATA_m    (HWDATA_m),
        .HRDATA_m    (HRDATA_m),
        .HREADY_m    (HREADY_m),
        .HRESP_m     (HRESP_m),
        .HADDR       (HADDR),
        .HWRITE      (HWRITE),
        .HTRANS      (HTRANS),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HMASTLOCK   (HMASTLOCK),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HMASTER     (HMASTER)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic       hready;
        logic       hresp;
        logic [1:0] exp_master;
        logic [1:0] exp_htrans;
        logic [3:0] exp_ready_m;
        logic [3:0] exp_resp_m;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic [3:0] req, input logic hready, input logic hresp,
                                input logic [1:0] m, input logic [1:0] tr,
                                input logic [3:0] rdy, input logic [3:0] rsp);
        vec_t v;
        v.req = req; v.hready = hready; v.hresp = hresp;
        v.exp_master = m; v.exp_htrans = tr; v.exp_ready_m = rdy; v.exp_resp_m = rsp;
        return v;
    endfunction

    function automatic logic [31:0] addr_of(input logic [1:0] m);
        return 32'h1000_0000 | {22'd0, m, 8'h40};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic [3:0] r);
        for (int i = 0; i < N; i++) begin
            HTRANS_m[i] = r[i] ? 2'b10 : 2'b00;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0;
        HRDATA  = 32'h0;
        HREADY  = 1'b1;
        HRESP   = 1'b0;
        for (int i = 0; i < N; i++) begin
            HADDR_m[i]     = addr_of(2'(i));
            HWRITE_m[i]    = 1'b0;
            HTRANS_m[i]    = 2'b00;
            HSIZE_m[i]     = 3'b010;
            HBURST_m[i]    = 3'b000;
            HPROT_m[i]     = 4'(i + 4);
            HMASTLOCK_m[i] = 1'b0;
            HWDATA_m[i]    = 32'h0;
        end

        //             req     rdy  rsp  mst   trans  ready_m  resp_m
        vecs[0]  = mk(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 4'b1111, 4'b0000); // parked on 0
        vecs[1]  = mk(4'b0100, 1'b1, 1'b0, 2'd2, 2'd2, 4'b1111, 4'b0000); // m2 zero-cycle grant
        vecs[2]  = mk(4'b0000, 1'b1, 1'b0, 2'd3, 2'd0, 4'b1111, 4'b0000); // ptr moved to 3
        vecs[3]  = mk(4'b1011, 1'b1, 1'b0, 2'd3, 2'd2, 4'b1100, 4'b0000); // 0,1,3 from ptr 3
        vecs[4]  = mk(4'b0011, 1'b1, 1'b0, 2'd0, 2'd2, 4'b1101, 4'b0000); // wrap to 0
        vecs[5]  = mk(4'b0010, 1'b1, 1'b0, 2'd1, 2'd2, 4'b1111, 4'b0000);
        vecs[6]  = mk(4'b1001, 1'b1, 1'b0, 2'd3, 2'd2, 4'b1110, 4'b0000); // ptr 2 -> 3 before 0
        vecs[7]  = mk(4'b0001, 1'b1, 1'b0, 2'd0, 2'd2, 4'b1111, 4'b0000);
        vecs[8]  = mk(4'b0010, 1'b0, 1'b0, 2'd1, 2'd2, 4'b1100, 4'b0000); // wait state
        vecs[9]  = mk(4'b0110, 1'b0, 1'b0, 2'd1, 2'd2, 4'b1000, 4'b0000); // m2 cannot steal
        vecs[10] = mk(4'b0110, 1'b1, 1'b0, 2'd1, 2'd2, 4'b1011, 4'b0000); // m1 accepted
        vecs[11] = mk(4'b0100, 1'b1, 1'b0, 2'd2, 2'd2, 4'b1111, 4'b0000);
        vecs[12] = mk(4'b0000, 1'b0, 1'b1, 2'd3, 2'd0, 4'b0011, 4'b0100); // ERROR cycle 1
        vecs[13] = mk(4'b0000, 1'b1, 1'b1, 2'd3, 2'd0, 4'b1111, 4'b0100); // ERROR cycle 2
        vecs[14] = mk(4'b0000, 1'b1, 1'b0, 2'd3, 2'd0, 4'b1111, 4'b0000);

        // Reset state
        #2;
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_hmaster", 32'(HMASTER), 32'h0);
        check("rst_ready_m", 32'(HREADY_m), 32'hF);
        HRESP = 1'b1;
        #1;
        check("rst_resp_m", 32'(HRESP_m), 32'h0);
        HRESP = 1'b0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Table-driven per-cycle vectors
        for (int v = 0; v < 15; v++) begin
            @(negedge HCLK);
            drive_req(vecs[v].req);
            HREADY = vecs[v].hready;
            HRESP  = vecs[v].hresp;
            #1;
            check($sformatf("v%0d_hmaster", v), 32'(HMASTER), 32'(vecs[v].exp_master));
            check($sformatf("v%0d_htrans", v), 32'(HTRANS), 32'(vecs[v].exp_htrans));
            check($sformatf("v%0d_haddr", v), HADDR, addr_of(vecs[v].exp_master));
            check($sformatf("v%0d_hprot", v), 32'(HPROT), 32'(vecs[v].exp_master) + 32'd4);
            check($sformatf("v%0d_ready_m", v), 32'(HREADY_m), 32'(vecs[v].exp_ready_m));
            check($sformatf("v%0d_resp_m", v), 32'(HRESP_m), 32'(vecs[v].exp_resp_m));
        end

        // Fresh start for directed sequences: ptr=0
        @(negedge HCLK);
        drive_req(4'b0000);
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Pipelined write: m2 address phase, then m2 data overlaps m3 address
        @(negedge HCLK);
        drive_req(4'b0100);
        HWRITE_m[2] = 1'b1;
        #1;
        check("pipe_a_hmaster", 32'(HMASTER), 32'd2);
        check("pipe_a_hwrite", 32'(HWRITE), 32'd1);
        @(negedge HCLK);
        drive_req(4'b1000);
        HWRITE_m[2] = 1'b0;
        HWDATA_m[2] = 32'hDEAD_BEEF;
        HRDATA      = 32'h1234_5678;
        #1;
        check("pipe_b_hwdata", HWDATA, 32'hDEAD_BEEF);
        check("pipe_b_hmaster", 32'(HMASTER), 32'd3);
        check("pipe_b_hwrite", 32'(HWRITE), 32'd0);
        check("pipe_b_ready2", 32'(HREADY_m[2]), 32'd1);
        check("pipe_b_ready3", 32'(HREADY_m[3]), 32'd1);
        check("pipe_b_hrdata2", HRDATA_m[2], 32'h1234_5678);

        // m1 held in wait state with m3 data phase pending, then async reset
        @(negedge HCLK);
        drive_req(4'b0010);
        HREADY = 1'b0;
        #1;
        check("rw_a_hmaster", 32'(HMASTER), 32'd1);
        check("rw_a_ready_m", 32'(HREADY_m), 32'h5);
        @(negedge HCLK);
        drive_req(4'b0011);
        #1;
        check("rw_b_hmaster", 32'(HMASTER), 32'd1);
        check("rw_b_ready0", 32'(HREADY_m[0]), 32'd0);
        #2;
        HRESP   = 1'b1;
        HRESETn = 1'b0;
        #1;
        check("rw_rst_hmaster", 32'(HMASTER), 32'd0);
        check("rw_rst_resp_m", 32'(HRESP_m), 32'h0);
        drive_req(4'b0000);
        HREADY = 1'b1;
        HRESP  = 1'b0;
        #1;
        check("rw_rst_htrans", 32'(HTRANS), 32'd0);
        check("rw_rst_ready_m", 32'(HREADY_m), 32'hF);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Round robin from ptr=0 with masters 0,1,3: 0, 1, 3, then 0 again
        @(negedge HCLK);
        drive_req(4'b1011);
        #1;
        check("rr_0", 32'(HMASTER), 32'd0);
        @(negedge HCLK);
        drive_req(4'b1010);
        #1;
        check("rr_1", 32'(HMASTER), 32'd1);
        check("rr_1_ready3", 32'(HREADY_m[3]), 32'd0);
        @(negedge HCLK);
        drive_req(4'b1001);
        #1;
        check("rr_3", 32'(HMASTER), 32'd3);
        @(negedge HCLK);
        drive_req(4'b0001);
        #1;
        check("rr_0_again", 32'(HMASTER), 32'd0);
        @(negedge HCLK);
        drive_req(4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ahb_lite_master_arbiter
`default_nettype wire
